opb_register_bank_ppc2simulink: RTL

Parametrised successor to the single OPB software register. It provides C_NUM_REGS software-writable 32-bit registers behind one OPB slave decode window, with byte-enable writes and read-back. It also drives a one-cycle per-register update strobe to fabric logic. An optional commit mode makes multi-register writes atomic, so coupled settings (seeds, gains, thresholds) reach fabric logic together. The user-side outputs run in the OPB clock domain.

---
 rtl/opb_register_bank_ppc2simulink_if.sv | 31 +++
 rtl/opb_register_bank_ppc2simulink.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/opb_register_bank_ppc2simulink_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : opb_register_bank_ppc2simulink_if
// Purpose  : OPB master/slave signal bundle for the register bank.
//            Bus vectors keep the big-endian OPB numbering [0:31].
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface opb_register_bank_ppc2simulink_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface
`default_nettype wire

// File: rtl/opb_register_bank_ppc2simulink.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : opb_register_bank_ppc2simulink
// Purpose  : Bank of C_NUM_REGS software-writable 32-bit registers behind one
//            OPB slave window, with per-register update strobes and an
//            optional shadow/commit mode for atomic multi-register updates.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR    = 32'h01014D00,
  parameter logic [31:0] C_HIGHADDR    = 32'h01014DFF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          C_NUM_REGS    = 4,
  parameter int          C_COMMIT_MODE = 0,
  parameter logic [31:0] C_INIT_VALUE  = 32'h00000000
) (
  input  wire logic                       OPB_Clk,
  input  wire logic                       OPB_Rst_n,
  opb_register_bank_ppc2simulink_if.slave opb,
  output logic [32*C_NUM_REGS-1:0]        user_data_out,
  output logic [C_NUM_REGS-1:0]           user_update
);

  localparam logic [29:0] CTRL_WORD = 30'(C_NUM_REGS);

  typedef enum logic [0:0] {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t state;
  logic   ack_q;
  logic [31:0] rd_q;

  // Bus vectors are [0:31]; positional assignment maps DBus[i] to bit 31-i
  // and BE[0] to be[3] (the most significant byte).
  logic [C_OPB_AWIDTH-1:0] addr;
  logic [C_OPB_AWIDTH-1:0] diff;
  logic [C_OPB_DWIDTH-1:0] wdata;
  logic [3:0]              be;
  logic [29:0]             word;
  logic                    hit;
  logic                    wr_hit;
  logic                    commit;
  logic [31:0]             rdata;
  logic [31:0]             rd_val [C_NUM_REGS];
  logic [C_NUM_REGS-1:0]   w_wr;
  logic [C_NUM_REGS-1:0]   upd_next;
  logic [C_NUM_REGS-1:0]   pending_q;
  logic                    unused;

  assign addr   = opb.OPB_ABus;
  assign wdata  = opb.OPB_DBus;
  assign be     = opb.OPB_BE;
  assign diff   = addr - C_BASEADDR;
  assign word   = diff[31:2];
  assign unused = opb.OPB_seqAddr;

  // A transfer is only accepted from IDLE; the cycle after an ack is
  // always spent returning to IDLE, so held selects ack every other cycle.
  assign hit    = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR)
                  && (state == IDLE);
  assign wr_hit = hit && !opb.OPB_RNW;
  assign commit = wr_hit && (word == CTRL_WORD) && wdata[0] && be[0]
                  && (C_COMMIT_MODE != 0);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  en);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (en[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_reg
    logic [31:0] out_q;
    assign w_wr[k] = wr_hit && (word == 30'(k));
    assign user_data_out[32*k +: 32] = out_q;

    if (C_COMMIT_MODE != 0) begin : g_commit
      logic [31:0] shadow_q;
      // Writes land in the shadow; the output only moves on a commit.
      always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
          shadow_q <= C_INIT_VALUE;
          out_q    <= C_INIT_VALUE;
        end else begin
          if (w_wr[k]) shadow_q <= merge_bytes(shadow_q, wdata, be);
          if (commit && pending_q[k]) out_q <= shadow_q;
        end
      end
      assign rd_val[k]   = shadow_q;
      assign upd_next[k] = commit && pending_q[k];
    end else begin : g_direct
      // Writes go straight to the fabric-facing register.
      always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) out_q <= C_INIT_VALUE;
        else if (w_wr[k]) out_q <= merge_bytes(out_q, wdata, be);
      end
      assign rd_val[k]   = out_q;
      assign upd_next[k] = w_wr[k] && (be != 4'b0000);
    end
  end

  // Read mux: registers, then the pending mask at the CTRL word, else zero.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      if (word == 30'(k)) rdata = rd_val[k];
    end
    if ((C_COMMIT_MODE != 0) && (word == CTRL_WORD)) rdata = 32'(pending_q);
  end

  // Pending mask: set by shadow writes, cleared wholesale by a commit.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) pending_q <= '0;
    else if (commit) pending_q <= '0;
    else if (C_COMMIT_MODE != 0) pending_q <= pending_q | w_wr;
  end

  // Update strobes line up with the cycle the outputs take their new value.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) user_update <= '0;
    else user_update <= upd_next;
  end

  // Two-state bus FSM with registered ack and read data.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state <= IDLE;
      ack_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state <= ACK;
            ack_q <= 1'b1;
            rd_q  <= opb.OPB_RNW ? rdata : 32'h0;
          end
        end
        default: begin
          state <= IDLE;
          ack_q <= 1'b0;
          rd_q  <= '0;
        end
      endcase
    end
  end

  assign opb.Sl_xferAck = ack_q;
  assign opb.Sl_DBus    = rd_q;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

endmodule
`default_nettype wire
